// File: rtl/band_gain_mixer_if.sv
// Frame, gain-write, output and saturation-counter signals of the band gain mixer.
// The master drives frames and gain writes; the mixer itself is the slave.
interface band_gain_mixer_if #(
  parameter int NUM_BANDS   = 8,
  parameter int AUDIO_WIDTH = 24,
  parameter int GAIN_WIDTH  = 16
) ();
  localparam int ADDR_W = $clog2(NUM_BANDS);

  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_BANDS*AUDIO_WIDTH-1:0] in_bands;
  logic                             gain_wr_en;
  logic [ADDR_W-1:0]                gain_wr_addr;
  logic [GAIN_WIDTH-1:0]            gain_wr_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [AUDIO_WIDTH-1:0]           out_sample;
  logic                             out_sat;
  logic [15:0]                      sat_cnt;
  logic                             sat_cnt_clr;

  modport master (
    output in_valid, in_bands, gain_wr_en, gain_wr_addr, gain_wr_data,
           out_ready, sat_cnt_clr,
    input  in_ready, out_valid, out_sample, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_bands, gain_wr_en, gain_wr_addr, gain_wr_data,
           out_ready, sat_cnt_clr,
    output in_ready, out_valid, out_sample, out_sat, sat_cnt
  );
endinterface

// File: rtl/band_gain_mixer.sv
// Multiplies each band of a frame by its fixed-point gain, one band per cycle,
// sums the scaled terms and emits a saturated mix with a clip counter.
module band_gain_mixer #(
  parameter int NUM_BANDS      = 8,
  parameter int AUDIO_WIDTH    = 24,
  parameter int GAIN_WIDTH     = 16,
  parameter int GAIN_FRAC_BITS = 14,
  parameter int ACC_WIDTH      = 48,
  parameter int ROUND_EN       = 1
) (
  input logic              clk,
  input logic              rst,
  band_gain_mixer_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_BANDS);
  localparam int PROD_W = AUDIO_WIDTH + GAIN_WIDTH;

  localparam logic signed [GAIN_WIDTH-1:0] UNITY_GAIN =
    {{(GAIN_WIDTH-1){1'b0}}, 1'b1} << GAIN_FRAC_BITS;
  localparam logic signed [ACC_WIDTH-1:0] ROUND_ADD = (ROUND_EN != 0) ?
    ({{(ACC_WIDTH-1){1'b0}}, 1'b1} << (GAIN_FRAC_BITS - 1)) : '0;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-AUDIO_WIDTH+1){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-AUDIO_WIDTH+1){1'b1}}, {(AUDIO_WIDTH-1){1'b0}}};
  localparam logic [AUDIO_WIDTH-1:0] MAX_SAMPLE = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic [AUDIO_WIDTH-1:0] MIN_SAMPLE = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic signed [GAIN_WIDTH-1:0]  r_gain  [NUM_BANDS];
  logic signed [GAIN_WIDTH-1:0]  r_snap  [NUM_BANDS];
  logic signed [AUDIO_WIDTH-1:0] r_bands [NUM_BANDS];
  logic [ADDR_W-1:0]             r_idx;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [AUDIO_WIDTH-1:0]        r_outSample;
  logic                          r_outSat;
  logic [15:0]                   r_satCnt;

  logic                          w_inReady;
  logic                          w_outValid;
  logic                          w_accept;
  logic                          w_xfer;
  logic                          w_lastBand;
  logic                          w_addrOk;
  logic signed [PROD_W-1:0]      w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prodExt;
  logic signed [ACC_WIDTH-1:0]   w_rounded;
  logic signed [ACC_WIDTH-1:0]   w_term;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic                          w_sat;
  logic [AUDIO_WIDTH-1:0]        w_satSample;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) begin
          w_nextState = ACCUM;
        end
      end
      ACCUM: begin
        if (w_lastBand) begin
          w_nextState = OUTPUT;
        end
      end
      OUTPUT: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_accept   = w_inReady && bus.in_valid;
  assign w_xfer     = w_outValid && bus.out_ready;
  assign w_lastBand = (r_state == ACCUM) && (r_idx == ADDR_W'(NUM_BANDS - 1));
  assign w_addrOk   = int'(bus.gain_wr_addr) < NUM_BANDS;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < NUM_BANDS; g++) begin
        r_gain[g] <= UNITY_GAIN;
      end
    end else if (bus.gain_wr_en && w_addrOk) begin
      r_gain[bus.gain_wr_addr] <= bus.gain_wr_data;
    end
  end

  // Scaled term is formed in the accumulator width so the rounding add never overflows.
  assign w_prod      = r_bands[r_idx] * r_snap[r_idx];
  assign w_prodExt   = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_rounded   = w_prodExt + ROUND_ADD;
  assign w_term      = w_rounded >>> GAIN_FRAC_BITS;
  assign w_sum       = r_acc + w_term;

  always_comb begin
    w_sat       = 1'b0;
    w_satSample = w_sum[AUDIO_WIDTH-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat       = 1'b1;
      w_satSample = MAX_SAMPLE;
    end else if (w_sum < SAT_MIN) begin
      w_sat       = 1'b1;
      w_satSample = MIN_SAMPLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_bands[b] <= '0;
        r_snap[b]  <= '0;
      end
      r_idx       <= '0;
      r_acc       <= '0;
      r_outSample <= '0;
      r_outSat    <= 1'b0;
    end else if (w_accept) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_bands[b] <= bus.in_bands[b*AUDIO_WIDTH +: AUDIO_WIDTH];
      end
      r_snap <= r_gain;
      r_idx  <= '0;
      r_acc  <= '0;
    end else if (r_state == ACCUM) begin
      r_acc <= w_sum;
      if (w_lastBand) begin
        r_idx       <= '0;
        r_outSample <= w_satSample;
        r_outSat    <= w_sat;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // A clear in the same cycle as a clipped transfer wins, leaving the count at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_satCnt <= '0;
    end else if (bus.sat_cnt_clr) begin
      r_satCnt <= '0;
    end else if (w_xfer && r_outSat && (r_satCnt != 16'hFFFF)) begin
      r_satCnt <= r_satCnt + 16'd1;
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = w_outValid;
  assign bus.out_sample = r_outSample;
  assign bus.out_sat    = r_outSat;
  assign bus.sat_cnt    = r_satCnt;
endmodule

// File: doc/band_gain_mixer.md
BAND_GAIN_MIXER -- requirements
Module: band_gain_mixer

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 8: number of input bands, minimum 2.
REQ-002 SHALL have parameter AUDIO_WIDTH, default 24: signed sample width, in and out.
REQ-003 SHALL have parameter GAIN_WIDTH, default 16: signed gain width.
REQ-004 SHALL have parameter GAIN_FRAC_BITS, default 14: gain fractional bits; unity gain is 1<<GAIN_FRAC_BITS.
REQ-005 SHALL have parameter ACC_WIDTH, default 48: accumulator width, required to be at least AUDIO_WIDTH+GAIN_WIDTH+clog2(NUM_BANDS).
REQ-006 SHALL have parameter ROUND_EN, default 1: 1 selects round-half-up after scaling, 0 selects truncation (floor).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port in_valid, input, 1 bit: a band frame is presented.
REQ-010 SHALL have port in_ready, output, 1 bit: the block can accept a frame.
REQ-011 SHALL have port in_bands, input, NUM_BANDS*AUDIO_WIDTH bits: band b occupies bits [b*AUDIO_WIDTH +: AUDIO_WIDTH].
REQ-012 SHALL have port gain_wr_en, input, 1 bit: gain register write strobe.
REQ-013 SHALL have port gain_wr_addr, input, clog2(NUM_BANDS) bits: band index to write.
REQ-014 SHALL have port gain_wr_data, input, GAIN_WIDTH bits: signed gain value to write.
REQ-015 SHALL have port out_valid, output, 1 bit: a mixed sample is available.
REQ-016 SHALL have port out_ready, input, 1 bit: the downstream block accepts the sample.
REQ-017 SHALL have port out_sample, output, AUDIO_WIDTH bits: signed saturated mix.
REQ-018 SHALL have port out_sat, output, 1 bit: out_sample was clipped.
REQ-019 SHALL have port sat_cnt, output, 16 bits: count of clipped output samples.
REQ-020 SHALL have port sat_cnt_clr, input, 1 bit: clears sat_cnt.

Function
REQ-021 SHALL hold a gain register file of NUM_BANDS entries; gain_wr_en writes gain_wr_data to entry gain_wr_addr in any state; out-of-range addresses (non-power-of-2 NUM_BANDS) are ignored.
REQ-022 SHALL implement states IDLE, ACCUM and OUTPUT; in_ready is 1 only in IDLE.
REQ-023 SHALL, in IDLE on in_valid&&in_ready, register in_bands, snapshot the full gain file, clear the accumulator and band index, and go to ACCUM.
REQ-024 SHALL take gain snapshot values from before a gain write in the same cycle as acceptance; that write affects the next frame only.
REQ-025 SHALL, in ACCUM, process one band per cycle for bands 0..NUM_BANDS-1 in order: p = sample*gain at full product width.
REQ-026 SHALL, with ROUND_EN=1, add 2^(GAIN_FRAC_BITS-1) to p before the arithmetic shift right by GAIN_FRAC_BITS; with ROUND_EN=0 apply the shift only.
REQ-027 SHALL sign-extend each scaled term to ACC_WIDTH and add it to the accumulator with no intermediate saturation.
REQ-028 SHALL, after the last band, saturate the accumulator to [-2^(AUDIO_WIDTH-1), 2^(AUDIO_WIDTH-1)-1], register it as out_sample, set out_sat if clipped, and go to OUTPUT.
REQ-029 SHALL assert out_valid in OUTPUT; a frame accepted at edge T gives out_valid=1 at edge T+NUM_BANDS+1.
REQ-030 SHALL keep out_valid, out_sample and out_sat stable while out_valid&&!out_ready.
REQ-031 SHALL, on out_valid&&out_ready, return to IDLE so that in_ready=1 the next cycle; throughput is one frame per NUM_BANDS+2 cycles at best.
REQ-032 SHALL increment sat_cnt by 1 at the out_sat transfer, holding at 0xFFFF.
REQ-033 SHALL let sat_cnt_clr take priority over a same-cycle increment, giving 0.

Reset
REQ-034 SHALL, on rst=1 at a clock edge in any state including mid-ACCUM, set: state IDLE, in_ready=1, out_valid=0, out_sample=0, out_sat=0, sat_cnt=0, accumulator=0, band index=0, and every gain entry to unity.
REQ-035 SHALL discard any in-flight frame on reset, giving no output for it.
REQ-036 SHALL give rst priority over gain writes and handshakes in the same cycle.

Verification
REQ-037 SHALL cover: defaults, unity gains, all bands 0x000100 -> out_sample 0x000800, out_sat=0, out_valid exactly 9 cycles after acceptance.
REQ-038 SHALL cover: all bands 0x7FFFFF at unity -> 0x7FFFFF, out_sat=1, sat_cnt=1; all bands 0x800000 -> 0x800000, sat_cnt=2.
REQ-039 SHALL cover: all bands 0x000001, all gains 0x2000 (0.5) -> 0x000008 with ROUND_EN=1, 0x000000 with ROUND_EN=0; and gain 0xC000 (-1.0) on band 3 only, bands 0x000010 -> 0x000060.
REQ-040 SHALL cover: out_ready held low for 5 cycles -> out_valid and out_sample stable, in_ready=0; transfer -> in_ready=1 next cycle.
REQ-041 SHALL cover: gain write to band 0 of 0 in the acceptance cycle -> that frame uses the old gain, the next frame excludes band 0.
REQ-042 SHALL cover: rst asserted at ACCUM band 4 -> next cycle in_ready=1, out_valid=0, all gains unity, and no stale output appears.
